// File: rtl/core_imem_responder.sv
// Instruction-fetch responder: valid/ready slave backed by a word array with a loader write port.
// Responds after a fixed number of wait states and flags misaligned or out-of-range fetches.
module core_imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           imem_valid,
    output logic                           imem_ready,
    input  logic [31:0]                    imem_addr,
    output logic [31:0]                    imem_rdata,
    output logic                           imem_fault,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_wdata
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    // 33 bits so the byte span of a 2^30-word array still fits.
    localparam logic [32:0] Limit = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic          capture;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_off;
    logic [AW-1:0] cap_idx;
    logic          cap_fault;

    logic [31:0] mem [DEPTH_WORDS];

    // Unsigned subtraction: addresses below the base wrap to huge offsets and land out of range.
    assign cap_off   = cap_addr - BASE_ADDR;
    assign cap_idx   = cap_off[AW+1:2];
    assign cap_fault = (cap_addr[1:0] != 2'b00) || ({1'b0, cap_off} >= Limit);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        capture  = 1'b0;
        cap_addr = addr_q;
        unique case (state_q)
            StIdle: begin
                if (imem_valid) begin
                    addr_d = imem_addr;
                    if (WAIT_CYCLES == 0) begin
                        capture  = 1'b1;
                        cap_addr = imem_addr;
                        state_d  = StResp;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!imem_valid) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (capture) begin
                fault_q <= cap_fault;
                rdata_q <= cap_fault ? 32'd0 : mem[cap_idx];
            end
        end
    end

    // A load in the capture cycle lands after the read, so the fetch sees the old word.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    assign imem_ready = (state_q == StResp) & imem_valid;
    assign imem_rdata = rdata_q;
    assign imem_fault = fault_q & imem_ready;

endmodule

// File: doc/core_imem_responder.md
Name: core_imem_responder

Overview:
- Responder side of the core instruction-fetch valid/ready interface.
- Accepts word-fetch requests from the fetch stage and returns one 32-bit instruction per handshake.
- Backed by an internal word-addressed array, with a configurable number of wait states.
- Provides a loader write port so the testbench or boot logic can preload program images.
- Flags out-of-range and misaligned fetches.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0 of the array.
- DEPTH_WORDS, 1024: number of 32-bit words; power of 2, at least 2.
- WAIT_CYCLES, 0: extra wait states inserted before the response; legal range 0..15.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- imem_valid  input  1  fetch request valid; requester holds it high, with imem_addr stable, until imem_ready.
- imem_ready  output  1  response strobe; the handshake completes in the cycle where imem_valid & imem_ready.
- imem_addr  input  32  byte address of the requested instruction.
- imem_rdata  output  32  instruction word; valid whenever imem_ready=1.
- imem_fault  output  1  qualifies imem_ready: the fetch was out of range or misaligned.
- ld_we  input  1  loader write enable.
- ld_addr  input  $clog2(DEPTH_WORDS)  loader word index.
- ld_wdata  input  32  loader write data.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, wait counter=0.
  - Internal registers rdata_q=0 and fault_q=0, so imem_rdata=0 and imem_fault=0.
  - imem_ready=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP. The wait counter is 4 bits.
- IDLE:
  - On imem_valid=1: latch addr_q=imem_addr.
  - If WAIT_CYCLES=0: perform the read capture this cycle and go to RESP.
  - Otherwise: load counter=WAIT_CYCLES-1 and go to WAIT.
  - imem_ready=0 in IDLE.
- WAIT:
  - If imem_valid=0: abort to IDLE with no response.
  - Else if counter=0: perform the read capture and go to RESP.
  - Else: decrement the counter.
- Read capture:
  - Word index = (addr_q - BASE_ADDR) >> 2.
  - Misaligned when addr_q[1:0]!=0.
  - Out of range when (addr_q - BASE_ADDR) >= 4*DEPTH_WORDS, using unsigned 32-bit subtraction, so addresses below BASE_ADDR wrap and count as out of range.
  - On fault: rdata_q=0, fault_q=1. Otherwise: rdata_q=mem[index], fault_q=0.
  - In IDLE with WAIT_CYCLES=0, the capture uses imem_addr directly.
- RESP:
  - imem_ready = (state==RESP) & imem_valid, driven from a state register with no combinational path from imem_addr.
  - imem_rdata = rdata_q; imem_fault = fault_q & imem_ready.
  - Always returns to IDLE next cycle, whether or not imem_valid is still high.
  - If imem_valid=0 in RESP, the response is dropped silently.
- Latency:
  - Valid first seen at cycle T gives ready at cycle T+1+WAIT_CYCLES.
  - Throughput is one fetch per 2+WAIT_CYCLES cycles.
  - No back-to-back acceptance from RESP.
- Requester updating its PC right after the handshake: the new address is sampled fresh in IDLE; addr_q never carries over between requests.
- Loader port:
  - On ld_we, write mem[ld_addr]=ld_wdata at the clock edge; this operates in any state.
  - A write in the same cycle as a read capture to the same index returns the OLD data.
  - A write in an earlier cycle is visible to the read.
- Reset asserted mid-transaction returns to IDLE immediately and drops imem_ready within the same cycle (asynchronous).
- Array implementation must be inferable as a single-port-read, single-port-write RAM; reads are registered only via the capture.

Test Plan:
- WAIT_CYCLES=0, mem[0]=32'h0000_0093, request addr 0 at cycle T -> imem_ready=1 at T+1 with rdata=32'h0000_0093 and fault=0; imem_ready=0 at T+2.
- WAIT_CYCLES=3, BASE_ADDR=32'h8000_0000, mem[5]=32'hDEAD_BEEF, request addr 32'h8000_0014 held -> imem_ready exactly at T+4 with rdata=32'hDEAD_BEEF.
- Fault cases, each -> ready with fault=1 and rdata=0:
  - addr 32'h0000_0002 (misaligned).
  - addr 4*DEPTH_WORDS (out of range).
  - addr BASE_ADDR-4 with BASE_ADDR=32'h8000_0000 (wrap, out of range).
- Abort: WAIT_CYCLES=4, drop imem_valid at T+2 -> no ready pulse; state back in IDLE; a new request at T+5 completes at T+10.
- Loader collision: mem[3]=A; ld_we to index 3 with B in the capture cycle -> response A; repeat the fetch -> response B.
- Stream of 8 sequential fetches from addr 0, WAIT_CYCLES=1, requester re-asserting valid every cycle -> handshakes 3 cycles apart with the correct words; assert rst_n=0 mid-WAIT -> imem_ready=0, rdata=0 immediately.
